// File: rtl/reg_universal.sv
// reg_universal -- parameterized universal register.
//
// A WIDTH-bit register supporting hold, parallel load, shift left/right with
// serial fill, rotate left/right, invert and increment. Synchronous
// active-low clear (to RST_VAL) wins over synchronous active-low preset
// (to all ones), which wins over the enabled operation.
//
// Ports
//   clk     in   1      clock, all state changes on rising edge
//   clr     in   1      synchronous clear, active low, loads RST_VAL
//   pr      in   1      synchronous preset, active low, loads all ones
//   en      in   1      operation enable
//   mode    in   3      operation select
//   d       in   WIDTH  parallel load data
//   sin_r   in   1      serial in at bit 0 on shift left
//   sin_l   in   1      serial in at bit WIDTH-1 on shift right
//   q       out  WIDTH  register state
//   nq      out  WIDTH  ~q
//   sout_l  out  1      q[WIDTH-1]
//   sout_r  out  1      q[0]
//   tc      out  1      q is all ones
//   zero    out  1      q is all zeros
module reg_universal #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             sout_l,
  output logic             sout_r,
  output logic             tc,
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_INV  = 3'b110,
    OP_INC  = 3'b111
  } op_e;

  logic [WIDTH-1:0] q_q, q_d;
  op_e              op;

  assign op = op_e'(mode);

  // Next state excluding clear; clear is applied in the flop process so it
  // overrides everything at the edge.
  always_comb begin
    q_d = q_q;
    if (!pr) begin
      q_d = '1;
    end else if (en) begin
      case (op)
        OP_HOLD: q_d = q_q;
        OP_LOAD: q_d = d;
        OP_SHL:  q_d = {q_q[WIDTH-2:0], sin_r};
        OP_SHR:  q_d = {sin_l, q_q[WIDTH-1:1]};
        OP_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        OP_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        OP_INV:  q_d = ~q_q;
        OP_INC:  q_d = q_q + WIDTH'(1);  // wraps, carry discarded
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) q_q <= RST_VAL;
    else      q_q <= q_d;
  end

  assign q      = q_q;
  assign nq     = ~q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign tc     = &q_q;
  assign zero   = ~|q_q;

endmodule

// File: tb/tb_reg_universal.sv
// Directed bench for reg_universal: an 8-bit instance runs the main
// sequences, a 4-bit instance repeats the increment-wrap case. Every cycle
// the full output set is compared against a hand-computed expected q.
module tb_reg_universal;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       clr8, pr8, en8, sinr8, sinl8;
  logic [2:0] mode8;
  logic [7:0] d8, q8, nq8;
  logic       sl8, sr8, tc8, z8;

  // 4-bit instance
  logic       clr4, pr4, en4, sinr4, sinl4;
  logic [2:0] mode4;
  logic [3:0] d4, q4, nq4;
  logic       sl4, sr4, tc4, z4;

  int n_chk  = 0;
  int n_fail = 0;

  reg_universal #(.WIDTH(8), .RST_VAL(8'h00)) dut8 (
    .clk(clk), .clr(clr8), .pr(pr8), .en(en8), .mode(mode8), .d(d8),
    .sin_r(sinr8), .sin_l(sinl8), .q(q8), .nq(nq8),
    .sout_l(sl8), .sout_r(sr8), .tc(tc8), .zero(z8)
  );

  reg_universal #(.WIDTH(4), .RST_VAL(4'h0)) dut4 (
    .clk(clk), .clr(clr4), .pr(pr4), .en(en4), .mode(mode4), .d(d4),
    .sin_r(sinr4), .sin_l(sinl4), .q(q4), .nq(nq4),
    .sout_l(sl4), .sout_r(sr4), .tc(tc4), .zero(z4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full output check against an expected q value of width w.
  task automatic chk_all(input string tag, input int w,
                         input logic [31:0] oq, input logic [31:0] onq,
                         input logic osl, input logic osr,
                         input logic otc, input logic oz,
                         input logic [31:0] exp);
    logic [31:0] mask;
    mask = (32'h1 << w) - 32'h1;
    chk({tag, ".q"},      oq,  exp & mask);
    chk({tag, ".nq"},     onq, ~exp & mask);
    chk({tag, ".sout_l"}, {31'b0, osl}, {31'b0, exp[w-1]});
    chk({tag, ".sout_r"}, {31'b0, osr}, {31'b0, exp[0]});
    chk({tag, ".tc"},     {31'b0, otc}, {31'b0, (exp & mask) == mask});
    chk({tag, ".zero"},   {31'b0, oz},  {31'b0, (exp & mask) == 32'h0});
  endtask

  task automatic step8(input string tag, input logic c, input logic p, input logic e,
                       input logic [2:0] m, input logic [7:0] dd,
                       input logic sr, input logic sl, input logic [7:0] exp);
    clr8 = c; pr8 = p; en8 = e; mode8 = m; d8 = dd; sinr8 = sr; sinl8 = sl;
    @(posedge clk); #1;
    chk_all(tag, 8, {24'b0, q8}, {24'b0, nq8}, sl8, sr8, tc8, z8, {24'b0, exp});
  endtask

  task automatic step4(input string tag, input logic c, input logic p, input logic e,
                       input logic [2:0] m, input logic [3:0] dd, input logic [3:0] exp);
    clr4 = c; pr4 = p; en4 = e; mode4 = m; d4 = dd; sinr4 = 1'b0; sinl4 = 1'b0;
    @(posedge clk); #1;
    chk_all(tag, 4, {28'b0, q4}, {28'b0, nq4}, sl4, sr4, tc4, z4, {28'b0, exp});
  endtask

  initial begin
    clr8 = 1'b0; pr8 = 1'b1; en8 = 1'b0; mode8 = 3'd0; d8 = 8'h00; sinr8 = 1'b0; sinl8 = 1'b0;
    clr4 = 1'b0; pr4 = 1'b1; en4 = 1'b0; mode4 = 3'd0; d4 = 4'h0; sinr4 = 1'b0; sinl4 = 1'b0;

    // Reset beats preset, then preset, then disabled load holds
    step8("rst",       0, 0, 1, 3'b001, 8'h5A, 0, 0, 8'h00);
    step8("preset",    1, 0, 1, 3'b001, 8'h12, 0, 0, 8'hFF);
    step8("en0_hold",  1, 1, 0, 3'b001, 8'h5A, 0, 0, 8'hFF);
    step8("en0_inc",   1, 1, 0, 3'b111, 8'h00, 1, 1, 8'hFF);

    // Load / shift
    step8("load_a5",   1, 1, 1, 3'b001, 8'hA5, 0, 0, 8'hA5);
    step8("shl",       1, 1, 1, 3'b010, 8'h00, 1, 0, 8'h4B);
    step8("shr",       1, 1, 1, 3'b011, 8'h00, 0, 0, 8'h25);
    step8("shr_sinl",  1, 1, 1, 3'b011, 8'h00, 0, 1, 8'h92);
    step8("hold",      1, 1, 1, 3'b000, 8'h33, 1, 1, 8'h92);

    // Rotate / invert
    step8("load_81",   1, 1, 1, 3'b001, 8'h81, 0, 0, 8'h81);
    step8("rol",       1, 1, 1, 3'b100, 8'h00, 0, 0, 8'h03);
    step8("ror1",      1, 1, 1, 3'b101, 8'h00, 0, 0, 8'h81);
    step8("ror2",      1, 1, 1, 3'b101, 8'h00, 0, 0, 8'hC0);
    step8("inv",       1, 1, 1, 3'b110, 8'h00, 0, 0, 8'h3F);

    // Increment wrap
    step8("load_fe",   1, 1, 1, 3'b001, 8'hFE, 0, 0, 8'hFE);
    step8("inc_ff",    1, 1, 1, 3'b111, 8'h00, 0, 0, 8'hFF);
    step8("inc_wrap",  1, 1, 1, 3'b111, 8'h00, 0, 0, 8'h00);
    step8("inc_01",    1, 1, 1, 3'b111, 8'h00, 0, 0, 8'h01);

    // Clear aborts a counting sequence and the count restarts from RST_VAL
    step8("load_10",   1, 1, 1, 3'b001, 8'h10, 0, 0, 8'h10);
    step8("inc_11",    1, 1, 1, 3'b111, 8'h00, 0, 0, 8'h11);
    step8("inc_12",    1, 1, 1, 3'b111, 8'h00, 0, 0, 8'h12);
    step8("clr_abort", 0, 1, 1, 3'b111, 8'h00, 0, 0, 8'h00);
    step8("clr_pr",    0, 0, 1, 3'b111, 8'h00, 0, 0, 8'h00);
    step8("restart",   1, 1, 1, 3'b111, 8'h00, 0, 0, 8'h01);

    // 4-bit increment wrap
    step4("w4_rst",    0, 1, 0, 3'b000, 4'h0, 4'h0);
    step4("w4_load_e", 1, 1, 1, 3'b001, 4'hE, 4'hE);
    step4("w4_inc_f",  1, 1, 1, 3'b111, 4'h0, 4'hF);
    step4("w4_wrap",   1, 1, 1, 3'b111, 4'h0, 4'h0);
    step4("w4_preset", 1, 0, 1, 3'b001, 4'h5, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_universal.md
REG_UNIVERSAL -- requirements
Module: reg_universal

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 Parameter RST_VAL, default 0, value loaded into q by reset; WIDTH bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clr  input  1  synchronous active-low reset.
REQ-005 pr  input  1  synchronous active-low preset.
REQ-006 en  input  1  active-high operation enable.
REQ-007 mode  input  3  operation select, encoding per REQ-013.
REQ-008 d  input  WIDTH  parallel load data.
REQ-009 sin_r  input  1  serial input, enters bit 0 on shift left.
REQ-010 sin_l  input  1  serial input, enters bit WIDTH-1 on shift right.
REQ-011 q  output  WIDTH  registered state; nq  output  WIDTH  bitwise complement of q.
REQ-012 sout_l  output  1  equals q[WIDTH-1]; sout_r  output  1  equals q[0]; tc  output  1  high when q is all ones; zero  output  1  high when q is all zeros; all four are combinational from q.

Function
REQ-013 When en=1 on a rising edge, mode SHALL select one operation:
- 000: hold.
- 001: load, q<=d.
- 010: shift left, q<={q[W-2:0],sin_r}.
- 011: shift right, q<={sin_l,q[W-1:1]}.
- 100: rotate left, q<={q[W-2:0],q[W-1]}.
- 101: rotate right, q<={q[0],q[W-1:1]}.
- 110: invert, q<=~q.
- 111: increment, q<=q+1 mod 2^WIDTH.
REQ-014 Priority per edge SHALL be: clr=0 first, then pr=0, then en=1 with mode, otherwise hold.
REQ-015 pr=0 with clr=1 SHALL set q to all ones on the next edge, regardless of en and mode.
REQ-016 en=0 with clr=1 and pr=1 SHALL hold q for any mode, d or serial input.
REQ-017 Increment from all ones SHALL wrap to all zeros in one cycle, with no carry-out port; tc is high in the cycle before the wrap.
REQ-018 Every operation SHALL have 1-cycle latency: q reflects the operation in the cycle after the sampling edge.
REQ-019 nq SHALL equal ~q at all times, including during and after reset.
REQ-020 No output SHALL be X after the first reset edge; inputs sampled only at rising clk edges, none asynchronous.

Reset
REQ-021 clr=0 at a rising edge SHALL load q=RST_VAL and nq=~RST_VAL, overriding pr, en and mode.
REQ-022 Before the first reset edge, outputs are undefined; the bench SHALL apply clr=0 for at least one edge before checking.
REQ-023 clr asserted in mid-sequence (for example, during increment) SHALL abort the operation at that edge; the next operation restarts from RST_VAL.
REQ-024 With RST_VAL=0: after reset, zero=1, tc=0, sout_l=0, sout_r=0.

Verification (WIDTH=8, RST_VAL=0)
REQ-025 clr=0,pr=0 one edge -> q=00, nq=FF, zero=1; then clr=1,pr=0 -> q=FF, tc=1; then pr=1,en=0, mode=001, d=5A -> q stays FF.
REQ-026 en=1, mode=001, d=A5 -> q=A5, nq=5A. Then mode=010, sin_r=1 -> q=4B. Then mode=011, sin_l=0 -> q=25, sout_r=1.
REQ-027 Load 81. mode=100 -> q=03. mode=101 twice -> q=81 then C0. mode=110 -> q=3F.
REQ-028 Load FE, mode=111 -> q=FF with tc=1, then q=00 with zero=1 and tc=0, then q=01.
REQ-029 Incrementing from 10, apply clr=0 at the third edge -> q=12 then q=00. Hold clr=0 with pr=0 -> q stays 00.
REQ-030 The bench SHALL check nq==~q and all four flags every cycle across scenarios REQ-025..REQ-029, and SHALL repeat REQ-028 with WIDTH=4 (E->F->0).
